// File: rtl/nand_flash_pkg.sv
// Shared definitions for the small-page NAND flash reader and writer:
// command opcodes, reader state encoding and address-cycle helpers.
package nand_flash_pkg;

  localparam logic [7:0] CMD_READ0        = 8'h00;
  localparam logic [7:0] CMD_READ1        = 8'h01;
  localparam logic [7:0] CMD_PROG         = 8'h80;
  localparam logic [7:0] CMD_PROG_CONFIRM = 8'h10;

  localparam int ADDR_CYCLES = 3;
  localparam int TIMER_W     = 16;

  localparam logic [3:0] RD_ST_IDLE       = 4'd0;
  localparam logic [3:0] RD_ST_CMD_1      = 4'd1;
  localparam logic [3:0] RD_ST_CMD_2      = 4'd2;
  localparam logic [3:0] RD_ST_CMD_3      = 4'd3;
  localparam logic [3:0] RD_ST_ADDR       = 4'd4;
  localparam logic [3:0] RD_ST_WAIT_BUSY  = 4'd5;
  localparam logic [3:0] RD_ST_WAIT_READY = 4'd6;
  localparam logic [3:0] RD_ST_RD_LOW     = 4'd7;
  localparam logic [3:0] RD_ST_RD_OUT     = 4'd8;
  localparam logic [3:0] RD_ST_RD_HIGH    = 4'd9;
  localparam logic [3:0] RD_ST_FINISH     = 4'd10;

  typedef enum logic [3:0] {
    S_IDLE       = RD_ST_IDLE,
    S_CMD_1      = RD_ST_CMD_1,
    S_CMD_2      = RD_ST_CMD_2,
    S_CMD_3      = RD_ST_CMD_3,
    S_ADDR       = RD_ST_ADDR,
    S_WAIT_BUSY  = RD_ST_WAIT_BUSY,
    S_WAIT_READY = RD_ST_WAIT_READY,
    S_RD_LOW     = RD_ST_RD_LOW,
    S_RD_OUT     = RD_ST_RD_OUT,
    S_RD_HIGH    = RD_ST_RD_HIGH,
    S_FINISH     = RD_ST_FINISH
  } reader_state_t;

  // Column cycle is always 0; row bytes come from the page-aligned byte address.
  function automatic logic [7:0] read_addr_byte(input logic [1:0] idx, input logic [23:0] addr);
    case (idx)
      2'd0:    return 8'h00;
      2'd1:    return addr[16:9];
      default: return {1'b0, addr[23:17]};
    endcase
  endfunction

endpackage

// File: rtl/nand_flash_reader_state_machine_timer.sv
// Loadable down-counter with a zero flag, shared by the RE low/high and
// busy-timeout intervals of the flash reader.
module nand_strobe_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/nand_flash_reader_state_machine.sv
// Sequential page reader for the small-page NAND array: command, three address
// cycles, tR wait, then RE-strobed bytes delivered over valid/ready.
module nand_flash_reader_state_machine
  import nand_flash_pkg::*;
#(
  parameter int          PAGE_BYTES   = 512,
  parameter logic [23:0] TOTAL_BYTES  = 24'h40000,
  parameter int          RE_LOW       = 2,
  parameter int          RE_HIGH      = 2,
  parameter int          BUSY_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        F_CLE_B,
  output logic        F_ALE_B,
  output logic        F_WEN_B,
  output logic        F_REN_B,
  output logic [7:0]  F_DIO_out,
  output logic        F_DIO_oe,
  input  logic [7:0]  F_DIO_in,
  input  logic        F_RB_B,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [23:0] address_count,
  output logic        done
);

  localparam int PAGE_W = $clog2(PAGE_BYTES);

  reader_state_t        state;
  logic [PAGE_W-1:0]    page_byte;
  logic [1:0]           addr_idx;
  logic                 addr_phase;
  logic                 timer_load;
  logic [TIMER_W-1:0]   timer_value;
  logic                 timer_zero;
  logic                 handshake;

  assign handshake = rd_valid && rd_ready;

  // Each interval is loaded with length-1 on the edge that enters its state,
  // so the zero flag marks the final cycle of that interval.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = '0;
    case (state)
      S_ADDR: begin
        if (addr_phase && addr_idx == 2'(ADDR_CYCLES - 1)) begin
          timer_load  = 1'b1;
          timer_value = TIMER_W'(BUSY_TIMEOUT - 1);
        end
      end
      S_WAIT_READY: begin
        if (F_RB_B) begin
          timer_load  = 1'b1;
          timer_value = TIMER_W'(RE_LOW - 1);
        end
      end
      S_RD_OUT: begin
        if (handshake) begin
          timer_load  = 1'b1;
          timer_value = TIMER_W'(RE_HIGH - 1);
        end
      end
      S_RD_HIGH: begin
        if (timer_zero && page_byte != '0) begin
          timer_load  = 1'b1;
          timer_value = TIMER_W'(RE_LOW - 1);
        end
      end
      default: ;
    endcase
  end

  nand_strobe_timer #(.W(TIMER_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_value),
    .zero       (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      F_CLE_B       <= 1'b0;
      F_ALE_B       <= 1'b0;
      F_WEN_B       <= 1'b1;
      F_REN_B       <= 1'b1;
      F_DIO_out     <= 8'h00;
      F_DIO_oe      <= 1'b0;
      rd_data       <= 8'h00;
      rd_valid      <= 1'b0;
      address_count <= 24'd0;
      done          <= 1'b0;
      page_byte     <= '0;
      addr_idx      <= 2'd0;
      addr_phase    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (address_count >= TOTAL_BYTES) begin
            state <= S_FINISH;
            done  <= 1'b1;
          end else if (en) begin
            state     <= S_CMD_1;
            F_CLE_B   <= 1'b1;
            F_DIO_oe  <= 1'b1;
            F_DIO_out <= CMD_READ0;
          end
        end
        S_CMD_1: begin
          state   <= S_CMD_2;
          F_WEN_B <= 1'b0;
        end
        S_CMD_2: begin
          state   <= S_CMD_3;
          F_WEN_B <= 1'b1;
        end
        S_CMD_3: begin
          state      <= S_ADDR;
          F_CLE_B    <= 1'b0;
          F_ALE_B    <= 1'b1;
          F_WEN_B    <= 1'b0;
          F_DIO_out  <= read_addr_byte(2'd0, address_count);
          addr_idx   <= 2'd0;
          addr_phase <= 1'b0;
        end
        // Two cycles per address byte: WE low, then WE high with data held.
        S_ADDR: begin
          if (!addr_phase) begin
            F_WEN_B    <= 1'b1;
            addr_phase <= 1'b1;
          end else if (addr_idx == 2'(ADDR_CYCLES - 1)) begin
            state     <= S_WAIT_BUSY;
            F_ALE_B   <= 1'b0;
            F_DIO_oe  <= 1'b0;
            F_DIO_out <= 8'h00;
          end else begin
            addr_idx   <= addr_idx + 2'd1;
            addr_phase <= 1'b0;
            F_WEN_B    <= 1'b0;
            F_DIO_out  <= read_addr_byte(addr_idx + 2'd1, address_count);
          end
        end
        S_WAIT_BUSY: begin
          if (!F_RB_B || timer_zero) state <= S_WAIT_READY;
        end
        S_WAIT_READY: begin
          if (F_RB_B) begin
            state   <= S_RD_LOW;
            F_REN_B <= 1'b0;
          end
        end
        S_RD_LOW: begin
          if (timer_zero) begin
            state    <= S_RD_OUT;
            F_REN_B  <= 1'b1;
            rd_data  <= F_DIO_in;
            rd_valid <= 1'b1;
          end
        end
        S_RD_OUT: begin
          if (handshake) begin
            state     <= S_RD_HIGH;
            rd_valid  <= 1'b0;
            page_byte <= page_byte + PAGE_W'(1);
            if (address_count < TOTAL_BYTES) address_count <= address_count + 24'd1;
          end
        end
        S_RD_HIGH: begin
          if (timer_zero) begin
            if (page_byte == '0) begin
              state <= S_IDLE;
            end else begin
              state   <= S_RD_LOW;
              F_REN_B <= 1'b0;
            end
          end
        end
        S_FINISH: begin
          done     <= 1'b1;
          F_CLE_B  <= 1'b0;
          F_ALE_B  <= 1'b0;
          F_WEN_B  <= 1'b1;
          F_REN_B  <= 1'b1;
          F_DIO_oe <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
